multicycle_control_fsm: RTL

- Main control state machine of the multicycle datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the branch-qualifier lines (isBEQ/isBNE/isBGT/isBLE) and the unconditional pc_write that the PC-write gating logic combines with ALU zero/gt.
- Is the producing end of that interface, and also drives all other datapath enables and muxes, including the memory read/write handshake.

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/mc_opcode_class.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, state encoding,
// datapath mux/ALU encodings and the bundled control-output record.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_EXCEPTION
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ADDI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } instrClass_t;

  typedef enum logic [1:0] {BR_EQ, BR_NE, BR_GT, BR_LE} brType_t;

  typedef struct packed {
    logic       pcWrite;
    logic       isBeq;
    logic       isBne;
    logic       isBgt;
    logic       isBle;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iord;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       epcWrite;
    logic       causeWrite;
  } ctrl_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode decoder: instruction class for the DECODE transition,
// branch flavour for the isB* qualifiers, and the jal link flag.
module mc_opcode_class
  import mc_pkg::*;
(
  input  logic [5:0]  opcode,
  output instrClass_t instrClass,
  output brType_t     brType,
  output logic        isJal
);

  always_comb begin
    instrClass = CLS_ILLEGAL;
    brType     = BR_EQ;
    isJal      = 1'b0;
    case (opcode)
      OP_RTYPE: instrClass = CLS_RTYPE;
      OP_ADDI:  instrClass = CLS_ADDI;
      OP_LW:    instrClass = CLS_LOAD;
      OP_SW:    instrClass = CLS_STORE;
      OP_BEQ:   begin instrClass = CLS_BRANCH; brType = BR_EQ; end
      OP_BNE:   begin instrClass = CLS_BRANCH; brType = BR_NE; end
      OP_BGT:   begin instrClass = CLS_BRANCH; brType = BR_GT; end
      OP_BLE:   begin instrClass = CLS_BRANCH; brType = BR_LE; end
      OP_J:     instrClass = CLS_JUMP;
      OP_JAL:   begin instrClass = CLS_JUMP; isJal = 1'b1; end
      default:  instrClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle datapath: fetch/decode/execute/memory/
// writeback sequencing, branch qualifiers, memory handshake and exception entry.
module multicycle_control_fsm
  import mc_pkg::*;
#(
  parameter bit EXC_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       isBEQ,
  output logic       isBNE,
  output logic       isBGT,
  output logic       isBLE,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic       cause_write
);

  state_t      state;
  state_t      nextState;
  logic [5:0]  opcodeQ;
  logic [5:0]  classOp;
  instrClass_t instrClass;
  brType_t     brType;
  logic        isJal;
  ctrl_t       ctrl;
  ctrl_t       ctrlOut;

  // The live IR is only trusted in DECODE; afterwards the latched copy rules.
  assign classOp = (state == S_DECODE) ? opcode : opcodeQ;

  mc_opcode_class uClass (
    .opcode     (classOp),
    .instrClass (instrClass),
    .brType     (brType),
    .isJal      (isJal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (state == S_DECODE) opcodeQ <= opcode;
  end

  always_comb begin
    nextState = S_FETCH;
    case (state)
      S_FETCH:     nextState = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instrClass)
          CLS_RTYPE:  nextState = S_R_EXEC;
          CLS_ADDI:   nextState = S_I_EXEC;
          CLS_LOAD,
          CLS_STORE:  nextState = S_MEM_ADDR;
          CLS_BRANCH: nextState = S_BRANCH;
          CLS_JUMP:   nextState = S_JUMP;
          default:    nextState = EXC_ENABLE ? S_EXCEPTION : S_FETCH;
        endcase
      end
      S_R_EXEC:    nextState = S_R_WB;
      S_I_EXEC:    nextState = S_I_WB;
      S_MEM_ADDR:  nextState = (instrClass == CLS_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  nextState = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nextState = mem_ready ? S_FETCH : S_MEM_WRITE;
      default:     nextState = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALU_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.pcWrite  = mem_ready;
        ctrl.irWrite  = mem_ready;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALU_ADD;
      end
      S_R_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RD;
        ctrl.memToReg = M2R_ALUOUT;
      end
      S_I_EXEC, S_MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      S_I_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RT;
        ctrl.memToReg = M2R_ALUOUT;
      end
      S_MEM_READ: begin
        ctrl.memRead = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RT;
        ctrl.memToReg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        ctrl.memWrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA  = 1'b1;
        ctrl.aluSrcB  = SRCB_B;
        ctrl.aluOp    = ALU_SUB;
        ctrl.pcSource = PCSRC_ALUOUT;
        case (brType)
          BR_EQ:   ctrl.isBeq = 1'b1;
          BR_NE:   ctrl.isBne = 1'b1;
          BR_GT:   ctrl.isBgt = 1'b1;
          default: ctrl.isBle = 1'b1;
        endcase
      end
      S_JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
        if (isJal) begin
          ctrl.regWrite = 1'b1;
          ctrl.regDst   = REGDST_RA;
          ctrl.memToReg = M2R_PC;
        end
      end
      S_EXCEPTION: begin
        ctrl.epcWrite   = 1'b1;
        ctrl.causeWrite = 1'b1;
        ctrl.pcWrite    = 1'b1;
        ctrl.pcSource   = PCSRC_EXC;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset silences every output in the same cycle, so no write escapes.
  assign ctrlOut = reset ? '0 : ctrl;

  assign pc_write    = ctrlOut.pcWrite;
  assign isBEQ       = ctrlOut.isBeq;
  assign isBNE       = ctrlOut.isBne;
  assign isBGT       = ctrlOut.isBgt;
  assign isBLE       = ctrlOut.isBle;
  assign ir_write    = ctrlOut.irWrite;
  assign mem_read    = ctrlOut.memRead;
  assign mem_write   = ctrlOut.memWrite;
  assign iord        = ctrlOut.iord;
  assign reg_write   = ctrlOut.regWrite;
  assign reg_dst     = ctrlOut.regDst;
  assign mem_to_reg  = ctrlOut.memToReg;
  assign alu_src_a   = ctrlOut.aluSrcA;
  assign alu_src_b   = ctrlOut.aluSrcB;
  assign alu_op      = ctrlOut.aluOp;
  assign pc_source   = ctrlOut.pcSource;
  assign epc_write   = ctrlOut.epcWrite;
  assign cause_write = ctrlOut.causeWrite;

endmodule
